// File: rtl/ped_crossing_scheduler.sv
// Demand-driven round-robin pedestrian crossing scheduler with a vehicle hold handshake.
// Define PED_PAIR_EN to serve crosswalks in pairs {north,south} / {east,west}.
module ped_crossing_scheduler #(
    parameter int unsigned WALK_CYC  = 8,
    parameter int unsigned FLASH_CYC = 4,
    parameter int unsigned CLEAR_CYC = 2,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       enable_p,
    input  logic [3:0] push,
    output logic       veh_hold_req,
    input  logic       veh_hold_ack,
    output logic [3:0] walk,
    output logic [3:0] flash,
    output logic [3:0] pending,
    output logic       busy
);

    localparam int unsigned N_XW  = 4;
    localparam int unsigned PTR_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WALK,
        S_FLASH,
        S_CLEAR,
        S_RELEASE
    } state_t;

    state_t             state_q;
    logic [N_XW-1:0]    gnt_q;
    logic [N_XW-1:0]    pend_q;
    logic [N_XW-1:0]    pend_d;
    logic [N_XW-1:0]    walk_q;
    logic [N_XW-1:0]    flash_q;
    logic [PTR_W-1:0]   rr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               req_q;
    logic               busy_q;

    logic [N_XW-1:0]    gnt_c;
    logic [PTR_W-1:0]   gnt_ptr_c;
    logic [N_XW-1:0]    push_mask_c;

`ifdef PED_PAIR_EN
    // Alternate between the two pairs; the pair's whole pending set is granted together.
    always_comb begin
        gnt_c     = '0;
        gnt_ptr_c = rr_q;
        if (rr_q[1]) begin
            if (pend_q[1:0] != 2'b00) begin
                gnt_c     = {2'b00, pend_q[1:0]};
                gnt_ptr_c = PTR_W'(1);
            end else begin
                gnt_c     = {pend_q[3:2], 2'b00};
                gnt_ptr_c = PTR_W'(3);
            end
        end else begin
            if (pend_q[3:2] != 2'b00) begin
                gnt_c     = {pend_q[3:2], 2'b00};
                gnt_ptr_c = PTR_W'(3);
            end else begin
                gnt_c     = {2'b00, pend_q[1:0]};
                gnt_ptr_c = PTR_W'(1);
            end
        end
    end
`else
    // First pending crosswalk searching upward from the one after the last grant.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        found     = 1'b0;
        idx       = '0;
        gnt_c     = '0;
        gnt_ptr_c = rr_q;
        for (int k = 1; k <= int'(N_XW); k++) begin
            idx = PTR_W'(rr_q + PTR_W'(k));
            if (!found && pend_q[idx]) begin
                found      = 1'b1;
                gnt_c[idx] = 1'b1;
                gnt_ptr_c  = idx;
            end
        end
    end
`endif

    // Presses on the crosswalk being served are dropped until it has walked.
    always_comb begin
        push_mask_c = '0;
        if (state_q inside {S_HOLD, S_WALK, S_FLASH}) begin
            push_mask_c = gnt_q;
        end
        pend_d = pend_q | (push & ~push_mask_c);
        if (state_q == S_HOLD && veh_hold_ack) begin
            pend_d = pend_d & ~gnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            pend_q  <= '0;
            walk_q  <= '0;
            flash_q <= '0;
            rr_q    <= PTR_W'(3);
            cnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                S_IDLE: begin
                    if (enable_p && pend_q != '0) begin
                        gnt_q   <= gnt_c;
                        rr_q    <= gnt_ptr_c;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (veh_hold_ack) begin
                        walk_q  <= gnt_q;
                        cnt_q   <= CNT_W'(WALK_CYC - 1);
                        state_q <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (cnt_q == '0) begin
                        walk_q  <= '0;
                        flash_q <= gnt_q;
                        cnt_q   <= CNT_W'(FLASH_CYC - 1);
                        state_q <= S_FLASH;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_FLASH: begin
                    if (cnt_q == '0) begin
                        flash_q <= '0;
                        cnt_q   <= CNT_W'(CLEAR_CYC - 1);
                        state_q <= S_CLEAR;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_CLEAR: begin
                    if (cnt_q == '0) begin
                        req_q   <= 1'b0;
                        state_q <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (!veh_hold_ack) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign veh_hold_req = req_q;
    assign walk         = walk_q;
    assign flash        = flash_q;
    assign pending      = pend_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ped_crossing_scheduler.sv
// Bench for ped_crossing_scheduler (default single-crosswalk build): a time-based
// service model is compared every cycle, plus directed literal expectations.
module tb_ped_crossing_scheduler;

    localparam int W = 8;
    localparam int F = 4;
    localparam int C = 2;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       enable_p;
    logic [3:0] push;
    logic       veh_hold_req;
    logic       veh_hold_ack;
    logic [3:0] walk;
    logic [3:0] flash;
    logic [3:0] pending;
    logic       busy;
    logic       ack_tie;
    logic       ack_man;

    always #5 clk = ~clk;

    assign veh_hold_ack = ack_tie ? veh_hold_req : ack_man;

    ped_crossing_scheduler #(
        .WALK_CYC (W),
        .FLASH_CYC(F),
        .CLEAR_CYC(C),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst_a       (rst_a),
        .enable_p    (enable_p),
        .push        (push),
        .veh_hold_req(veh_hold_req),
        .veh_hold_ack(veh_hold_ack),
        .walk        (walk),
        .flash       (flash),
        .pending     (pending),
        .busy        (busy)
    );

    // Model: a service is described by who is served and how long since its WALK began.
    logic [3:0] m_pend;
    int         m_rr;
    int         m_g;
    bit         m_busy;
    bit         m_acked;
    bit         m_rel;
    int         m_t;
    logic [3:0] m_old;
    logic [3:0] m_oh;
    bit         m_ack;
    bit         m_found;
    int         m_idx;

    function automatic logic [3:0] oh4(input int g);
        logic [3:0] v;
        v    = 4'b0000;
        v[g] = 1'b1;
        return v;
    endfunction

    function automatic bit in_service();
        return m_busy && m_acked && !m_rel;
    endfunction

    function automatic logic [3:0] exp_walk();
        return (in_service() && m_t < W) ? oh4(m_g) : 4'b0000;
    endfunction

    function automatic logic [3:0] exp_flash();
        return (in_service() && m_t >= W && m_t < W + F) ? oh4(m_g) : 4'b0000;
    endfunction

    function automatic bit exp_req();
        return m_busy && !m_rel;
    endfunction

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            m_pend  = 4'b0000;
            m_rr    = 3;
            m_g     = 0;
            m_busy  = 0;
            m_acked = 0;
            m_rel   = 0;
            m_t     = 0;
        end else begin
            m_ack = ack_tie ? exp_req() : ack_man;
            m_old = m_pend;
            m_oh  = oh4(m_g);
            if (!m_busy) begin
                m_pend = m_old | push;
                if (enable_p && m_old != 4'b0000) begin
                    m_found = 0;
                    for (int k = 1; k <= 4; k++) begin
                        m_idx = (m_rr + k) % 4;
                        if (!m_found && m_old[m_idx]) begin
                            m_found = 1;
                            m_g     = m_idx;
                        end
                    end
                    m_rr    = m_g;
                    m_busy  = 1;
                    m_acked = 0;
                    m_rel   = 0;
                end
            end else if (!m_acked) begin
                m_pend = m_old | (push & ~m_oh);
                if (m_ack) begin
                    m_acked      = 1;
                    m_t          = 0;
                    m_pend[m_g]  = 1'b0;
                end
            end else if (!m_rel) begin
                m_pend = (m_t < W + F) ? (m_old | (push & ~m_oh)) : (m_old | push);
                if (m_t == W + F + C - 1) m_rel = 1;
                else m_t = m_t + 1;
            end else begin
                m_pend = m_old | push;
                if (!m_ack) m_busy = 0;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: advance to the falling edge and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        if (!rst_a) begin
            chk("model_walk", 32'(walk), 32'(exp_walk()));
            chk("model_flash", 32'(flash), 32'(exp_flash()));
            chk("model_req", 32'(veh_hold_req), 32'(exp_req()));
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_pending", 32'(pending), 32'(m_pend));
            if (walk != 4'b0000 && flash != 4'b0000)
                chk("walk_flash_exclusive", 32'(walk & flash), 32'(0));
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0: return walk != 4'b0000;
            1: return walk == 4'b0000;
            2: return flash != 4'b0000;
            3: return flash == 4'b0000;
            4: return veh_hold_req;
            5: return !veh_hold_req;
            default: return !busy && pending == 4'b0000;
        endcase
    endfunction

    task automatic wait_until(input string name, input int which, input int budget);
        int i;
        i = 0;
        while (!cond(which) && i < budget) begin
            tick();
            i++;
        end
        if (!cond(which)) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_%s: condition %0d not reached in %0d cycles", name, which, budget);
        end
    endtask

    logic [3:0] exp_w [4];
    logic [3:0] exp_p [4];
    int         n;

    initial begin
        rst_a    = 1'b1;
        enable_p = 1'b1;
        push     = 4'b0000;
        ack_tie  = 1'b1;
        ack_man  = 1'b0;
        #12;
        chk("rst_walk", 32'(walk), 32'(0));
        chk("rst_flash", 32'(flash), 32'(0));
        chk("rst_req", 32'(veh_hold_req), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_pending", 32'(pending), 32'(0));
        @(negedge clk);
        rst_a = 1'b0;

        // Single east press, ack tied to req.
        push = 4'b0100;
        tick();
        push = 4'b0000;
        chk("east_pending", 32'(pending), 32'h4);
        chk("east_req_early", 32'(veh_hold_req), 32'(0));
        tick();
        chk("east_req_rise", 32'(veh_hold_req), 32'(1));
        chk("east_hold_walk", 32'(walk), 32'(0));
        tick();
        chk("east_walk", 32'(walk), 32'h4);
        chk("east_pending_clr", 32'(pending), 32'(0));
        n = 0;
        while (walk == 4'b0100 && n < 20) begin n++; tick(); end
        chk("east_walk_len", 32'(n), 32'(W));
        n = 0;
        while (flash == 4'b0100 && n < 20) begin n++; tick(); end
        chk("east_flash_len", 32'(n), 32'(F));
        n = 0;
        while (veh_hold_req && walk == 4'b0000 && flash == 4'b0000 && n < 20) begin n++; tick(); end
        chk("east_clear_len", 32'(n), 32'(C));
        chk("east_req_drop", 32'(veh_hold_req), 32'(0));
        wait_until("east_idle", 6, 10);

        // Reset in the third WALK cycle of a west service, with south pending.
        push = 4'b1000;
        tick();
        push = 4'b0000;
        wait_until("west_walk", 0, 10);
        chk("west_walk", 32'(walk), 32'h8);
        push = 4'b0010;
        tick();
        push = 4'b0000;
        tick();
        chk("pre_rst_pending", 32'(pending), 32'h2);
        #2 rst_a = 1'b1;
        #1;
        chk("mid_rst_walk", 32'(walk), 32'(0));
        chk("mid_rst_flash", 32'(flash), 32'(0));
        chk("mid_rst_req", 32'(veh_hold_req), 32'(0));
        chk("mid_rst_pending", 32'(pending), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_a = 1'b0;

        // All four at once: north first after reset, then round-robin.
        exp_w[0] = 4'b0001; exp_w[1] = 4'b0010; exp_w[2] = 4'b0100; exp_w[3] = 4'b1000;
        exp_p[0] = 4'b1110; exp_p[1] = 4'b1100; exp_p[2] = 4'b1000; exp_p[3] = 4'b0000;
        push = 4'b1111;
        tick();
        push = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wait_until("rr_walk", 0, 40);
            chk("rr_walk", 32'(walk), 32'(exp_w[k]));
            chk("rr_pending", 32'(pending), 32'(exp_p[k]));
            wait_until("rr_walk_end", 1, 40);
        end
        wait_until("rr_idle", 6, 40);

        // Ack arrives five cycles into HOLD and lingers three cycles into RELEASE.
        ack_tie = 1'b0;
        ack_man = 1'b0;
        push = 4'b1000;
        tick();
        push = 4'b0000;
        wait_until("dly_req", 4, 10);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("dly_hold_walk", 32'(walk), 32'(0));
            chk("dly_hold_req", 32'(veh_hold_req), 32'(1));
        end
        ack_man = 1'b1;
        tick();
        chk("dly_walk", 32'(walk), 32'h8);
        wait_until("dly_req_drop", 5, 30);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("dly_release_busy", 32'(busy), 32'(1));
        end
        ack_man = 1'b0;
        tick();
        chk("dly_idle", 32'(busy), 32'(0));
        ack_tie = 1'b1;

        // Disabled: the request latches but is not granted until enable returns.
        enable_p = 1'b0;
        push = 4'b0001;
        tick();
        push = 4'b0000;
        repeat (3) tick();
        chk("dis_pending", 32'(pending), 32'h1);
        chk("dis_req", 32'(veh_hold_req), 32'(0));
        chk("dis_busy", 32'(busy), 32'(0));
        enable_p = 1'b1;
        tick();
        chk("en_grant", 32'(veh_hold_req), 32'(1));
        wait_until("en_idle", 6, 30);

        // South re-pressed during its own WALK (dropped) and during CLEAR (kept).
        push = 4'b0010;
        tick();
        push = 4'b0000;
        wait_until("rp_walk", 0, 10);
        chk("rp_walk", 32'(walk), 32'h2);
        tick();
        push = 4'b0010;
        tick();
        push = 4'b0000;
        chk("rp_walk_ignored", 32'(pending), 32'(0));
        wait_until("rp_flash", 2, 20);
        wait_until("rp_clear", 3, 20);
        chk("rp_clear_req", 32'(veh_hold_req), 32'(1));
        push = 4'b0010;
        tick();
        push = 4'b0000;
        chk("rp_clear_latched", 32'(pending), 32'h2);
        wait_until("rp_release", 5, 10);
        wait_until("rp_walk2", 0, 20);
        chk("rp_walk2", 32'(walk), 32'h2);
        chk("rp_walk2_pending", 32'(pending), 32'(0));
        wait_until("rp_idle", 6, 40);

        // Sparse random traffic checked only against the model.
        for (int k = 0; k < 300; k++) begin
            push     = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            enable_p = ($urandom_range(0, 9) != 0);
            tick();
        end
        push     = 4'b0000;
        enable_p = 1'b1;
        wait_until("rand_idle", 6, 200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
